ins_load_controller: RTL

//  Sequences instruction delivery from the RX UART byte stream into the Instruction Memory

---
 rtl/ins_load_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ins_load_controller.sv
// Instruction loader: moves accepted RX UART bytes into the instruction register, strobes the
// memory load, issues to the datapath and waits for completion. Optional watchdog: INS_LOAD_CTRL_TIMEOUT_EN.
module ins_load_controller #(
    parameter logic [7:0]  HALT_OPCODE = 8'hFF,
    parameter int unsigned CNT_W       = 8
`ifdef INS_LOAD_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TO_CYCLES   = 255
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Rx_Valid_in,
    input  logic [7:0]       Rx_Byte_in,
    input  logic             Exec_Done_in,
    input  logic             Resume_in,
    input  logic             Clr_Ovr_in,
    output logic [7:0]       Ins_Byte_out,
    output logic             Load_INS_en_out,
    output logic             Exec_Start_out,
    output logic             Busy_out,
    output logic             Halted_out,
    output logic             Overrun_out,
    output logic             Timeout_out,
    output logic [CNT_W-1:0] Instr_Count_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic             is_halt_byte_c;
    logic             overrun_evt_c;
    logic             wd_expire_c;

    logic [7:0]       ins_byte_q, ins_byte_d;
    logic             load_q, load_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             ovr_q, ovr_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign is_halt_byte_c = (Rx_Byte_in == HALT_OPCODE);

    // Non-halt bytes arriving mid-sequence are dropped and flagged; HALT stays silent
    assign overrun_evt_c = Rx_Valid_in && !is_halt_byte_c &&
                           ((state_q == ST_LOAD) || (state_q == ST_ISSUE) || (state_q == ST_WAIT));

`ifdef INS_LOAD_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Counts completed WAIT cycles; held at zero outside WAIT so each entry starts fresh
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expire_c = (state_q == ST_WAIT) && !Exec_Done_in &&
                         (wd_cnt_q == WD_W'(TO_CYCLES - 1));
`else
    assign wd_expire_c = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Rx_Valid_in) begin
                    state_d = is_halt_byte_c ? ST_HALT : ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (Exec_Done_in || wd_expire_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (Resume_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; strobes are decoded from the upcoming state so they land in-state
    always_comb begin
        ins_byte_d = ins_byte_q;
        load_d     = (state_d == ST_LOAD);
        start_d    = (state_d == ST_ISSUE);
        busy_d     = (state_d != ST_IDLE);
        halted_d   = (state_d == ST_HALT);
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
        timeout_d  = timeout_q;

        if ((state_q == ST_IDLE) && Rx_Valid_in && !is_halt_byte_c) begin
            ins_byte_d = Rx_Byte_in;
        end

        if ((state_q == ST_LOAD) && (state_d == ST_ISSUE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (overrun_evt_c) begin
            ovr_d = 1'b1;
        end else if (Clr_Ovr_in) begin
            ovr_d = 1'b0;
        end

`ifdef INS_LOAD_CTRL_TIMEOUT_EN
        if (wd_expire_c) begin
            timeout_d = 1'b1;
        end
`else
        timeout_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ins_byte_q <= '0;
            load_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            ovr_q      <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ins_byte_q <= ins_byte_d;
            load_q     <= load_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            ovr_q      <= ovr_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Ins_Byte_out    = ins_byte_q;
    assign Load_INS_en_out = load_q;
    assign Exec_Start_out  = start_q;
    assign Busy_out        = busy_q;
    assign Halted_out      = halted_q;
    assign Overrun_out     = ovr_q;
    assign Timeout_out     = timeout_q;
    assign Instr_Count_out = cnt_q;

endmodule
